// File: rtl/raifes_per_console_pkg.sv
// Shared constants for the peripheral console: HASTI widths/encodings, register
// offsets, STATUS bit layout and the data-phase state encoding.
package raifes_per_console_pkg;

    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_TRANS_WIDTH = 2;
    localparam int HASTI_RESP_WIDTH  = 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [0:0] HRESP_OKAY  = 1'b0;
    localparam logic [0:0] HRESP_ERROR = 1'b1;

    // Register index = haddr[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_LEVEL_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_XFER      = 3'd1,
        ST_WAIT_FULL = 3'd2,
        ST_ERR1      = 3'd3,
        ST_ERR2      = 3'd4
    } dp_state_e;

    function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                                input logic [15:0] level);
        logic [31:0] w;
        w = 32'd0;
        w[STATUS_FULL_BIT]  = full;
        w[STATUS_EMPTY_BIT] = empty;
        w[STATUS_LEVEL_LSB +: 16] = level;
        return w;
    endfunction

endpackage

// File: rtl/raifes_sync_fifo.sv
// Synchronous FIFO with level count; a push while full succeeds only together
// with a pop in the same cycle. Head reads as zero when empty.
module raifes_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == (AW+1)'(0));
    assign level_o   = level_q;
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign dout_o    = empty_o ? WIDTH'(0) : mem_q[rd_ptr_q];

    // Storage array carries no reset; validity is tracked by the level counter
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy update
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= (AW+1)'(0);
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/raifes_per_console.sv
// HASTI peripheral-bus console: TXDATA/STATUS/CTRL/SCRATCH registers and a TX byte FIFO.
// Define RAIFES_PER_CONSOLE_ERR_EN to return two-cycle ERROR for offsets >= 0x10.
module raifes_per_console
    import raifes_per_console_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hsel,
    input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
    input  logic                         hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
    input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
    output logic                         hready,
    output logic [HASTI_RESP_WIDTH-1:0]  hresp,
    output logic                         tx_valid,
    output logic [7:0]                   tx_data,
    input  logic                         tx_ready
);

    dp_state_e     state_q, state_d;
    logic [1:0]    dp_addr_q, dp_addr_d;
    logic          dp_write_q, dp_write_d;
    logic          drain_en_q, drain_en_d;
    logic [31:0]   scratch_q, scratch_d;

    logic          fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
    logic [FIFO_AW:0] fifo_level_s;
    logic          tx_write_s, stall_s, addr_phase_s, addr_err_s, reg_wr_s;
    logic          unused_s;

    assign unused_s = ^{hsize, htrans[0], haddr[31:12], haddr[11:4], haddr[1:0]};

    assign tx_valid     = drain_en_q & ~fifo_empty_s;
    assign fifo_pop_s   = tx_valid & tx_ready;
    assign tx_write_s   = ((state_q == ST_XFER) || (state_q == ST_WAIT_FULL))
                          && dp_write_q && (dp_addr_q == REG_TXDATA);
    // A full FIFO stalls the TXDATA write unless a byte leaves in the same cycle
    assign stall_s      = tx_write_s & fifo_full_s & ~fifo_pop_s;
    assign fifo_push_s  = tx_write_s & ~stall_s;
    assign reg_wr_s     = (state_q == ST_XFER) && dp_write_q;
    assign addr_phase_s = hsel & htrans[1] & hready;

`ifdef RAIFES_PER_CONSOLE_ERR_EN
    assign addr_err_s = (haddr[11:4] != 8'h00);
`else
    assign addr_err_s = 1'b0;
`endif

    raifes_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push_s),
        .din_i   (hwdata[7:0]),
        .pop_i   (fifo_pop_s),
        .dout_o  (tx_data),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_s)
    );

    // Data-phase handshake outputs
    always_comb begin
        case (state_q)
            ST_XFER, ST_WAIT_FULL: begin
                hready = ~stall_s;
                hresp  = HRESP_OKAY;
            end
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            ST_ERR2: begin
                hready = 1'b1;
                hresp  = HRESP_ERROR;
            end
            default: begin
                hready = 1'b1;
                hresp  = HRESP_OKAY;
            end
        endcase
    end

    // Read data mux, driven only during a read data phase
    always_comb begin
        hrdata = 32'd0;
        if ((state_q == ST_XFER) && !dp_write_q) begin
            case (dp_addr_q)
                REG_STATUS:  hrdata = pack_status(fifo_full_s, fifo_empty_s, 16'(fifo_level_s));
                REG_CTRL:    hrdata = {31'd0, drain_en_q};
                REG_SCRATCH: hrdata = scratch_q;
                default:     hrdata = 32'd0;
            endcase
        end else begin
            hrdata = 32'd0;
        end
    end

    // Next-state and register-write logic
    always_comb begin
        state_d    = state_q;
        dp_addr_d  = dp_addr_q;
        dp_write_d = dp_write_q;
        drain_en_d = drain_en_q;
        scratch_d  = scratch_q;
        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (!hready) begin
                    state_d = ST_WAIT_FULL;
                end else if (addr_phase_s) begin
                    state_d    = addr_err_s ? ST_ERR1 : ST_XFER;
                    dp_addr_d  = haddr[3:2];
                    dp_write_d = hwrite;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (reg_wr_s && (dp_addr_q == REG_CTRL)) begin
            drain_en_d = hwdata[0];
        end else begin
            drain_en_d = drain_en_q;
        end
        if (reg_wr_s && (dp_addr_q == REG_SCRATCH)) begin
            scratch_d = hwdata;
        end else begin
            scratch_d = scratch_q;
        end
    end

    // State and register storage
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dp_addr_q  <= 2'd0;
            dp_write_q <= 1'b0;
            drain_en_q <= 1'b0;
            scratch_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            dp_addr_q  <= dp_addr_d;
            dp_write_q <= dp_write_d;
            drain_en_q <= drain_en_d;
            scratch_q  <= scratch_d;
        end
    end

endmodule
